// File: rtl/binary_to_bcd_formatter.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) feeding a
// seven-segment controller; results and point mask are held in output registers.
module binary_to_bcd_formatter #(
  parameter int BINARY_WIDTH = 27,
  parameter int NUM_DIGITS   = 8
) (
  input  logic                      clock,
  input  logic                      resetN,
  input  logic [BINARY_WIDTH-1:0]   valueIn,
  input  logic [NUM_DIGITS-1:0]     pointMaskIn,
  input  logic                      inValid,
  output logic                      inReady,
  output logic [NUM_DIGITS*4-1:0]   data,
  output logic [NUM_DIGITS-1:0]     pointEnable,
  output logic                      overflow,
  output logic                      done,
  output logic                      dbg_state
);

  localparam int BCD_W = NUM_DIGITS * 4;
  localparam int CNT_W = $clog2(BINARY_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BINARY_WIDTH - 1);

  // Handshake: a value transfers on any rising edge where inValid && inReady.
  // inReady is high only in IDLE; inValid may be raised without waiting for inReady.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [BINARY_WIDTH-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]        bcd_q, bcd_d;
  logic [BCD_W-1:0]        bcd_adj;
  logic                    ovf_q, ovf_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic [BCD_W-1:0]        data_q, data_d;
  logic [NUM_DIGITS-1:0]   point_q, point_d;
  logic                    overflow_q, overflow_d;
  logic                    done_q, done_d;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    mask_d     = mask_q;
    data_d     = data_q;
    point_d    = point_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (inValid) begin
          state_d = SHIFT;
          bin_d   = valueIn;
          mask_d  = pointMaskIn;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        bin_d = {bin_q[BINARY_WIDTH-2:0], 1'b0};
        bcd_d = {bcd_adj[BCD_W-2:0], bin_q[BINARY_WIDTH-1]};
        ovf_d = ovf_q | bcd_adj[BCD_W-1];
        cnt_d = cnt_q + CNT_W'(1);
        // Outputs change only here, so the display never sees partial sums.
        if (cnt_q == LAST_SHIFT) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (ovf_d) begin
            data_d     = '1;
            point_d    = '0;
            overflow_d = 1'b1;
          end else begin
            data_d     = bcd_d;
            point_d    = mask_q;
            overflow_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      mask_q     <= '0;
      data_q     <= '0;
      point_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      data_q     <= data_d;
      point_q    <= point_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign inReady     = (state_q == IDLE);
  assign data        = data_q;
  assign pointEnable = point_q;
  assign overflow    = overflow_q;
  assign done        = done_q;
  assign dbg_state   = state_q;

endmodule
